hex_result_tx: RTL and testbench

Serialises a 64-bit datapath result as an ASCII hexadecimal line over an 8N1 UART. It sits directly downstream of the top-level result register. On a start pulse it captures the value and operand size, then transmits `0x`, the hex digits MSB-first, and CR LF on `txd`. The sequencer and the byte serialiser are separate, so the serialiser can later be shared with the prompt-message path.

---
 rtl/hex_tx_pkg.sv | 34 +++
 rtl/uart_tx_byte.sv | 96 +++++++++
 rtl/hex_result_tx.sv | 127 ++++++++++++
 tb/tb_hex_result_tx.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hex_tx_pkg.sv
// Shared constants, sequencer state encoding and character helpers for the
// hex result printer.
package hex_tx_pkg;

    localparam logic [7:0] CH_0  = 8'h30;
    localparam logic [7:0] CH_X  = 8'h78;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [2:0] {
        SEQ_IDLE = 3'd0,
        SEQ_LOAD = 3'd1,
        SEQ_SEND = 3'd2,
        SEQ_NEXT = 3'd3,
        SEQ_FIN  = 3'd4
    } seq_state_e;

    // Uppercase hex digit: 0-9 -> '0'..'9', A-F -> 'A'..'F' ('A' - 10 = 0x37).
    function automatic logic [7:0] nib2ascii(input logic [3:0] nib);
        logic [7:0] ch;
        if (nib < 4'd10) begin
            ch = 8'h30 + {4'h0, nib};
        end else begin
            ch = 8'h37 + {4'h0, nib};
        end
        return ch;
    endfunction

    // Line length: "0x" + 4*(size_sel+1) digits + CR LF.
    function automatic logic [4:0] char_count(input logic [1:0] size_sel);
        return {1'b0, size_sel, 2'b00} + 5'd8;
    endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: start bit, eight data bits LSB first, one stop bit.
// txd is held in a register so the line never glitches between bits.
module uart_tx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_busy,
    output logic       byte_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_txd;
    logic             w_bit_end;

    assign w_bit_end = (r_cnt == CNT_LAST);

    // Bit timing and frame sequencing; the counter wraps to zero on every bit boundary.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= {CNT_W{1'b0}};
            r_bit   <= 3'd0;
            r_shift <= 8'h00;
            r_txd   <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= {CNT_W{1'b0}};
                    r_bit <= 3'd0;
                    r_txd <= 1'b1;
                    if (tx_start) begin
                        r_shift <= tx_data;
                        r_txd   <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt   <= {CNT_W{1'b0}};
                        r_txd   <= r_shift[0];
                        r_state <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= {CNT_W{1'b0}};
                        if (r_bit == 3'd7) begin
                            r_txd   <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_txd   <= r_shift[1];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt   <= {CNT_W{1'b0}};
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_txd   <= 1'b1;
                end
            endcase
        end
    end

    assign txd       = r_txd;
    assign tx_busy   = (r_state != S_IDLE);
    assign byte_done = (r_state == S_STOP) && w_bit_end;

endmodule

// File: rtl/hex_result_tx.sv
// Prints a captured 64-bit result as "0x<hex digits>\r\n" over the byte
// serialiser, one character per frame.
module hex_result_tx
    import hex_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [63:0] value,
    input  logic [1:0]  size_sel,
    output logic        txd,
    output logic        busy,
    output logic        done
);

    seq_state_e  r_state;
    logic [63:0] r_value;
    logic [1:0]  r_size;
    logic [4:0]  r_idx;
    logic        r_tx_start;
    logic [7:0]  r_tx_data;
    logic        r_busy;
    logic        r_done;

    logic [4:0]  w_nchar;
    logic [3:0]  w_nib_idx;
    logic [7:0]  w_char;
    logic        w_txd;
    logic        w_tx_busy;
    logic        w_byte_done;

    assign w_nchar = char_count(r_size);
    // Digit chars run from the most significant printed nibble down to nibble 0.
    assign w_nib_idx = 4'(w_nchar - 5'd3 - r_idx);

    // Character for the current index: prefix, hex digit, or line terminator.
    always_comb begin
        w_char = CH_0;
        if (r_idx == 5'd0) begin
            w_char = CH_0;
        end else if (r_idx == 5'd1) begin
            w_char = CH_X;
        end else if (r_idx == (w_nchar - 5'd2)) begin
            w_char = CH_CR;
        end else if (r_idx == (w_nchar - 5'd1)) begin
            w_char = CH_LF;
        end else begin
            w_char = nib2ascii(r_value[{w_nib_idx, 2'b00} +: 4]);
        end
    end

    // Line sequencer: capture on accept, then hand characters to the serialiser.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= SEQ_IDLE;
            r_value    <= 64'h0;
            r_size     <= 2'd0;
            r_idx      <= 5'd0;
            r_tx_start <= 1'b0;
            r_tx_data  <= 8'h00;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_tx_start <= 1'b0;
            case (r_state)
                SEQ_IDLE: begin
                    if (start && !r_busy) begin
                        r_value <= value;
                        r_size  <= size_sel;
                        r_idx   <= 5'd0;
                        r_busy  <= 1'b1;
                        r_state <= SEQ_LOAD;
                    end
                end
                SEQ_LOAD: begin
                    if (!w_tx_busy) begin
                        r_tx_data  <= w_char;
                        r_tx_start <= 1'b1;
                        r_state    <= SEQ_SEND;
                    end
                end
                SEQ_SEND: begin
                    if (w_byte_done) begin
                        r_state <= SEQ_NEXT;
                    end
                end
                SEQ_NEXT: begin
                    if (r_idx == (w_nchar - 5'd1)) begin
                        r_state <= SEQ_FIN;
                    end else begin
                        r_idx   <= r_idx + 5'd1;
                        r_state <= SEQ_LOAD;
                    end
                end
                SEQ_FIN: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= SEQ_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= SEQ_IDLE;
                end
            endcase
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx_byte (
        .clk      (clk),
        .rst      (rst),
        .tx_start (r_tx_start),
        .tx_data  (r_tx_data),
        .txd      (w_txd),
        .tx_busy  (w_tx_busy),
        .byte_done(w_byte_done)
    );

    assign txd  = w_txd;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_hex_result_tx.sv
// Scoreboard bench: a line model queues expected bytes and done times; a UART
// decoder and a done monitor compare what the DUT actually produces.
module tb_hex_result_tx;

    localparam int CPB = 4;
    localparam int P   = 10 * CPB + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [63:0] value = 64'h0;
    logic [1:0]  size_sel = 2'd0;
    logic        txd, busy, done;

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int acc_edge = -1;
    int done_edge = -1;

    logic [7:0] exp_q[$];
    int         done_q[$];

    bit         dec_active = 1'b0;
    int         dec_cnt = 0;
    logic [7:0] dec_byte = 8'h00;

    hex_result_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .start(start), .value(value),
        .size_sel(size_sel), .txd(txd), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: the text line the printer must emit for a value and size.
    task automatic expect_line(input logic [63:0] v, input logic [1:0] s);
        int d;
        int nib;
        d = 4 * (int'(s) + 1);
        exp_q.push_back(8'h30);
        exp_q.push_back(8'h78);
        for (int i = d - 1; i >= 0; i--) begin
            nib = int'((v >> (4 * i)) & 64'hF);
            exp_q.push_back(nib < 10 ? 8'(48 + nib) : 8'(55 + nib));
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Called at a negedge; the start is seen at the next rising edge.
    task automatic do_print(input logic [63:0] v, input logic [1:0] s);
        int e;
        e = cyc + 1;
        start = 1'b1;
        value = v;
        size_sel = s;
        if (e > done_edge) begin
            acc_edge  = e;
            done_edge = e + (8 + 4 * int'(s)) * P + 1;
            expect_line(v, s);
            done_q.push_back(done_edge);
        end
        @(negedge clk);
        start = 1'b0;
        value = {$urandom, $urandom};
        size_sel = 2'($urandom);
        check("busy_after_start", busy, (cyc >= acc_edge && cyc < done_edge));
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("rst_txd", txd, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        exp_q.delete();
        done_q.delete();
        done_edge = cyc;
        @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
    endtask

    // UART decoder: sample each bit half a clock into it.
    always @(negedge clk) begin
        if (!rst) begin
            dec_active = 1'b0;
        end else if (!dec_active) begin
            if (txd == 1'b0) begin
                dec_active = 1'b1;
                dec_cnt = 0;
            end
        end else begin
            dec_cnt++;
            if (dec_cnt % CPB == 0) begin
                if (dec_cnt / CPB <= 8) begin
                    dec_byte[dec_cnt / CPB - 1] = txd;
                end else begin
                    check("stop_bit", txd, 1'b1);
                    if (exp_q.size() == 0) begin
                        check("unexpected_byte", {56'h0, dec_byte}, 64'hFFFF);
                    end else begin
                        check("tx_byte", dec_byte, exp_q.pop_front());
                    end
                    dec_active = 1'b0;
                end
            end
        end
    end

    // Done monitor: latency, single pulse, busy drop coincident with done.
    always @(negedge clk) begin
        if (rst && done) begin
            if (done_q.size() == 0) begin
                check("unexpected_done", done, 1'b0);
            end else begin
                check("done_latency", cyc, done_q.pop_front());
                check("busy_at_done", busy, 1'b0);
                check("txd_idle_at_done", txd, 1'b1);
            end
        end else if (done_q.size() > 0 && cyc > done_q[0]) begin
            check("done_missing", cyc, done_q[0]);
            void'(done_q.pop_front());
        end
    end

    initial begin
        #1 rst = 1'b0;
        #1;
        check("reset_txd", txd, 1'b1);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        repeat (3) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk);

        do_print(64'h0000_0000_0000_BEEF, 2'd0);
        wait_until(done_edge);
        do_print(64'h0123_4567_89AB_CDEF, 2'd3);
        wait_until(done_edge);
        do_print(64'hFFFF_FFFF_0000_00A5, 2'd1);

        // Start in the middle of char 3 and in the FIN cycle: both dropped.
        wait_until(done_edge);
        do_print(64'h1234, 2'd0);
        wait_until(acc_edge + 3 * P + 2 + CPB + 6);
        do_print(64'h9999, 2'd0);
        wait_until(done_edge - 1);
        do_print(64'h7777, 2'd0);
        do_print(64'h5678, 2'd0);

        // Reset during a data bit of char 2, then a clean print.
        wait_until(done_edge);
        do_print(64'hDEAD, 2'd0);
        wait_until(acc_edge + 2 * P + 2 + CPB + 2);
        do_reset();
        do_print(64'h0042, 2'd0);

        // Back-to-back lines.
        wait_until(done_edge);
        do_print(64'h1, 2'd0);
        wait_until(done_edge);
        do_print(64'h2, 2'd0);

        for (int k = 0; k < 6; k++) begin
            wait_until(done_edge);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_print({$urandom, $urandom}, 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(1, 200)) @(negedge clk);
                do_print({$urandom, $urandom}, 2'($urandom_range(0, 3)));
            end
        end

        for (int i = 0; i < 3000; i++) begin
            if (exp_q.size() == 0 && done_q.size() == 0) break;
            @(negedge clk);
        end
        check("bytes_left", exp_q.size(), 0);
        check("dones_left", done_q.size(), 0);
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
